// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory controller:
// funct3 codes, FSM encoding and lane helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic sz_b(input logic [2:0] f3);
    return f3[1:0] == F3_B[1:0];
  endfunction

  function automatic logic sz_h(input logic [2:0] f3);
    return f3[1:0] == F3_H[1:0];
  endfunction

  function automatic logic [3:0] be_of(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] be;
    unique case (1'b1)
      sz_b(f3): be = 4'b0001 << a;
      sz_h(f3): be = 4'b0011 << {a[1], 1'b0};
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_of(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    logic [31:0] w;
    unique case (1'b1)
      sz_b(f3): w = {4{d[7:0]}};
      sz_h(f3): w = {2{d[15:0]}};
      default:  w = d;
    endcase
    return w;
  endfunction

  // funct3[1:0]==11 is handled as a word access
  function automatic logic mis_of(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic m;
    unique case (1'b1)
      sz_b(f3): m = 1'b0;
      sz_h(f3): m = a[0];
      default:  m = (f3[1:0] == F3_W[1:0] || f3[1:0] == 2'b11) && (a != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load lane select and sign/zero extension.
// Purely combinational so other load ports can share it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        zext;

  always_comb begin
    b    = rdata_i[{addr_i, 3'b000} +: 8];
    h    = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    zext = (funct3_i == F3_BU) || (funct3_i == F3_HU);
    unique case (1'b1)
      sz_b(funct3_i): data_o = zext ? {24'b0, b} : {{24{b[7]}}, b};
      sz_h(funct3_i): data_o = zext ? {16'b0, h} : {{16{h[15]}}, h};
      default:        data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller on a req/gnt/rvalid bus.
// Stalls the pipeline until the access finishes.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  Funct3_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] StoreData_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Misaligned,
  output logic        BusError
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  alo_q, alo_d;
  logic [31:0] rd_q, rd_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;
  logic        op;
  logic [31:0] ld_data;

  load_align u_align (
    .rdata_i  (dmem_rdata),
    .addr_i   (alo_q),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  assign op = MemRead_i | MemWrite_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    alo_d   = alo_q;
    rd_d    = rd_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (op && mis_of(Funct3_i, Addr_i[1:0])) begin
          state_d = S_DONE;
          mis_d   = 1'b1;
          rd_d    = '0;
        end else if (op) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          we_d    = ~MemRead_i;
          addr_d  = {Addr_i[31:2], 2'b00};
          be_d    = be_of(Funct3_i, Addr_i[1:0]);
          wdata_d = wdata_of(Funct3_i, StoreData_i);
          f3_d    = Funct3_i;
          alo_d   = Addr_i[1:0];
        end
      end
      S_REQ: begin
        if (!dmem_gnt) begin
          req_d = 1'b1;
        end else if (we_q) begin
          state_d = S_DONE;
          rd_d    = '0;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          state_d = S_DONE;
          rd_d    = ld_data;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_DONE;
          berr_d  = 1'b1;
          rd_d    = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      alo_q   <= '0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      alo_q   <= alo_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign ReadData   = rd_q;
  assign Misaligned = mis_q;
  assign BusError   = berr_q;
  assign Stall      = RESET & op & (state_q != S_DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit
// against a byte-level reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [2:0]  Funct3_i = 3'b0;
  logic [31:0] Addr_i = '0;
  logic [31:0] StoreData_i = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Misaligned;
  logic        BusError;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_model = '0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .Funct3_i(Funct3_i), .Addr_i(Addr_i), .StoreData_i(StoreData_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .ReadData(ReadData), .Stall(Stall),
    .Misaligned(Misaligned), .BusError(BusError)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ld_m(input logic [31:0] w, input logic [31:0] a,
                                        input logic [2:0] f3);
    int n;
    logic [31:0] v, mask;
    n = nbytes(f3);
    if (n == 4) return w;
    v = w >> (8 * int'(a[1:0]));
    mask = 32'((64'd1 << (8 * n)) - 64'd1);
    v = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic run_op(input string tag, input bit rd, input bit wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int gdly, input int rdly,
                        input logic [31:0] rdata);
    bit ld, mis, done, in_wait, exp_berr;
    int n_req, n_stall, wait_i, exp_stall, exp_req, n;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0] exp_be;
    ld = rd;
    n = nbytes(f3);
    mis = (int'(a[1:0]) % n) != 0;
    exp_be = 4'(((1 << n) - 1) << int'(a[1:0]));
    exp_wd = (n == 1) ? d[7:0] * 32'h01010101 :
             (n == 2) ? d[15:0] * 32'h00010001 : d;
    exp_req = mis ? 0 : gdly + 1;
    if (mis) exp_stall = 1;
    else if (ld) exp_stall = 2 + gdly + ((rdly < TO) ? rdly + 1 : TO);
    else exp_stall = 2 + gdly;
    exp_berr = ld && !mis && (rdly >= TO);
    exp_rd = (ld && !mis && rdly < TO) ? ld_m(rdata, a, f3) : 32'h0;
    n_req = 0; n_stall = 0; wait_i = 0; done = 0; in_wait = 0;
    MemRead_i = rd; MemWrite_i = wr; Funct3_i = f3; Addr_i = a; StoreData_i = d;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      #1;
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (!Stall) begin
        done = 1;
        chk({tag, ".mis"}, 32'(Misaligned), 32'(mis));
        chk({tag, ".berr"}, 32'(BusError), 32'(exp_berr));
        chk({tag, ".rdata"}, ReadData, exp_rd);
        chk({tag, ".stall"}, 32'(n_stall), 32'(exp_stall));
        chk({tag, ".nreq"}, 32'(n_req), 32'(exp_req));
        rd_model = exp_rd;
        dmem_gnt = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = ~rdata;
      end else begin
        n_stall++;
        if (in_wait) begin
          if (wait_i == rdly) begin
            dmem_rvalid = 1'b1;
            dmem_rdata = rdata;
          end
          wait_i++;
        end
        if (dmem_req) begin
          n_req++;
          chk({tag, ".addr"}, dmem_addr, {a[31:2], 2'b00});
          chk({tag, ".we"}, 32'(dmem_we), 32'(!ld));
          chk({tag, ".be"}, 32'(dmem_be), 32'(exp_be));
          if (!ld) chk({tag, ".wdata"}, dmem_wdata, exp_wd);
          if (n_req == gdly + 1) begin
            dmem_gnt = 1'b1;
            in_wait = ld;
          end
        end
      end
      @(posedge CLK);
      #1;
    end
    chk({tag, ".finished"}, 32'(done), 32'd1);
    MemRead_i = 1'b0;
    MemWrite_i = 1'b0;
    #1;
    chk({tag, ".idle_stall"}, 32'(Stall), 32'd0);
    chk({tag, ".idle_req"}, 32'(dmem_req), 32'd0);
    chk({tag, ".idle_pulse"}, 32'({Misaligned, BusError}), 32'd0);
    chk({tag, ".idle_hold"}, ReadData, rd_model);
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    MemRead_i = 1'b1;
    #1;
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.we", 32'(dmem_we), 32'd0);
    chk("rst.be", 32'(dmem_be), 32'd0);
    chk("rst.rdata", ReadData, 32'd0);
    chk("rst.flags", 32'({Misaligned, BusError}), 32'd0);
    chk("rst.stall", 32'(Stall), 32'd0);
    @(posedge CLK);
    #1;
    MemRead_i = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    run_op("lw", 1, 0, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF);
    run_op("lb", 1, 0, 3'b000, 32'h103, 0, 0, 1, 32'h80FFFF7F);
    run_op("lbu", 1, 0, 3'b100, 32'h103, 0, 1, 0, 32'h80FFFF7F);
    run_op("sh", 0, 1, 3'b001, 32'h102, 32'h0000ABCD, 4, 0, 0);
    run_op("lw_mis", 1, 0, 3'b010, 32'h101, 0, 0, 0, 32'h12345678);
    run_op("lh_to", 1, 0, 3'b001, 32'h100, 0, 0, 255, 32'h0);
    run_op("lw_last", 1, 0, 3'b010, 32'h104, 0, 0, TO - 1, 32'hCAFEF00D);

    MemRead_i = 1'b1; Funct3_i = 3'b010; Addr_i = 32'h200;
    @(posedge CLK); #1;
    #1 dmem_gnt = 1'b1;
    @(posedge CLK); #1;
    dmem_gnt = 1'b0;
    #1 RESET = 1'b0;
    #1;
    chk("rstw.req", 32'(dmem_req), 32'd0);
    chk("rstw.stall", 32'(Stall), 32'd0);
    chk("rstw.be", 32'(dmem_be), 32'd0);
    chk("rstw.rdata", ReadData, 32'd0);
    rd_model = '0;
    MemRead_i = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    run_op("reissue", 1, 0, 3'b010, 32'h200, 0, 0, 0, 32'h0BADF00D);

    for (int i = 0; i < 80; i++) begin
      bit r, w;
      int rdly;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) w = 1'b1;
      rdly = ($urandom_range(0, 5) == 0) ? 255 : int'($urandom_range(0, TO - 1));
      run_op($sformatf("rnd%0d", i), r, w, 3'($urandom_range(0, 7)), $urandom,
             $urandom, int'($urandom_range(0, 3)), rdly, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
